// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared types and helpers for the PPU framebuffer writer
package ppu_pkg;

  typedef enum logic [1:0] {
    H_BLANK = 2'd0,
    V_BLANK = 2'd1,
    SCAN    = 2'd2,
    DRAW    = 2'd3
  } ppu_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LINE  = 2'd1,
    FLUSH = 2'd2,
    VBL   = 2'd3
  } fb_wr_state_t;

  localparam int FB_BYTES_PER_LINE = 40;
  localparam int FB_BYTES          = 5760;
  localparam int FB_ADDR_W         = 13;
  localparam int FB_REQ_W          = FB_ADDR_W + 8;

  function automatic logic [FB_ADDR_W-1:0] fb_byte_addr(input logic [7:0] y,
                                                        input logic [5:0] xb);
    return (FB_ADDR_W'(y) * FB_ADDR_W'(FB_BYTES_PER_LINE)) + FB_ADDR_W'(xb);
  endfunction

  // Palette lookup: colour index idx selects bgp[2*idx+1 -: 2].
  function automatic logic [1:0] bgp_shade(input logic [7:0] bgp,
                                           input logic [1:0] idx);
    return bgp[{idx, 1'b1} -: 2];
  endfunction

endpackage

// File: rtl/ppu_fb_fifo.sv
// rtl/ppu_fb_fifo.sv - synchronous write-request FIFO between the packer and framebuffer port
module ppu_fb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 21
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is still accepted when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ppu_fb_writer.sv
// rtl/ppu_fb_writer.sv - palette-maps PPU pixels, packs 4 per byte and writes the 160x144 framebuffer
// Optional FB_DOUBLE_BUFFER_EN: fb_sel toggles on every frame_done.
module ppu_fb_writer
  import ppu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LINE_PX    = 160,
  parameter int LINES      = 144
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  px_in,
  input  logic        px_valid,
  input  logic [1:0]  ppu_mode,
  input  logic [7:0]  bgp,
  input  logic        lcd_en,
  output logic        fb_wr,
  output logic [12:0] fb_addr,
  output logic [7:0]  fb_wdata,
  input  logic        fb_ready,
  output logic        fb_sel,
  output logic        frame_done,
  output logic        ovf
);

  localparam logic [7:0] LINE_PX_B = 8'(LINE_PX);
  localparam logic [7:0] LINES_B   = 8'(LINES);

  fb_wr_state_t          state;
  logic [7:0]            x;
  logic [7:0]            y;
  logic [7:0]            pack;
  logic [1:0]            cnt;
  logic [1:0]            prev_mode;

  logic [1:0]            shade;
  logic                  vbl_entry;
  logic                  px_take;
  logic                  flush_push;
  logic                  push;
  logic [7:0]            padded;
  logic [FB_REQ_W-1:0]   push_data;
  logic [FB_REQ_W-1:0]   head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic [FB_ADDR_W-1:0]  cur_addr;

  assign shade     = bgp_shade(bgp, px_in);
  assign vbl_entry = lcd_en && (ppu_mode == V_BLANK) && (prev_mode != V_BLANK);
  assign px_take   = lcd_en && !vbl_entry && (state == LINE) && (ppu_mode == DRAW) &&
                     px_valid && (x < LINE_PX_B) && (y < LINES_B);
  assign flush_push = lcd_en && !vbl_entry && (state == FLUSH) && (cnt != 2'd0);
  assign push       = (px_take && (cnt == 2'd3)) || flush_push;
  assign cur_addr   = fb_byte_addr(y, x[7:2]);

  // Left-align the pending pixels so the first pixel of the group sits in [7:6].
  always_comb begin
    padded = pack;
    case (cnt)
      2'd1:    padded = {pack[1:0], 6'b0};
      2'd2:    padded = {pack[3:0], 4'b0};
      2'd3:    padded = {pack[5:0], 2'b0};
      default: padded = pack;
    endcase
  end

  always_comb begin
    push_data = {cur_addr, padded};
    if (px_take) begin
      push_data = {cur_addr, pack[5:0], shade};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      pack       <= '0;
      cnt        <= '0;
      prev_mode  <= H_BLANK;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      prev_mode  <= ppu_mode;
      frame_done <= 1'b0;
      if (push && fifo_full && !pop) begin
        ovf <= 1'b1;
      end
      if (!lcd_en) begin
        state <= IDLE;
        x     <= '0;
        y     <= '0;
        cnt   <= '0;
      end else if (vbl_entry) begin
        state      <= VBL;
        x          <= '0;
        y          <= '0;
        cnt        <= '0;
        frame_done <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (ppu_mode == DRAW) begin
              state <= LINE;
            end
          end
          LINE: begin
            if (ppu_mode != DRAW) begin
              state <= FLUSH;
            end else if (px_take) begin
              pack <= {pack[5:0], shade};
              cnt  <= cnt + 2'd1;
              x    <= x + 8'd1;
            end
          end
          FLUSH: begin
            x     <= '0;
            cnt   <= '0;
            state <= IDLE;
            if (y != 8'hFF) begin
              y <= y + 8'd1;
            end
          end
          VBL: begin
            y <= '0;
            if (ppu_mode == SCAN) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef FB_DOUBLE_BUFFER_EN
  logic fb_sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_sel_q <= 1'b0;
    end else if (vbl_entry) begin
      fb_sel_q <= !fb_sel_q;
    end
  end

  assign fb_sel = fb_sel_q;
`else
  assign fb_sel = 1'b0;
`endif

  ppu_fb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FB_REQ_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign fb_wr = !fifo_empty;
  assign pop   = fb_wr && fb_ready;
  // Head storage is not reset, so mask it while nothing is queued.
  assign {fb_addr, fb_wdata} = fifo_empty ? '0 : head;

endmodule
